// File: rtl/conv_reader.sv
// conv_reader: sequential 2x2 valid-mode 3x3 convolution of a snapshotted 4x4 image, one MAC per cycle, results over valid/ready.
module conv_reader #(
   parameter int DW = 8,
   parameter int AW = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [16*DW-1:0] in_flat,
   input  logic [9*DW-1:0]  filt_flat,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [AW-1:0]    out_data,
   output logic [1:0]       out_idx,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, LOAD, MAC, EMIT, DONE} state_t;
   state_t state_q, state_d;
   logic [16*DW-1:0] in_q, in_d;
   logic [9*DW-1:0] filt_q, filt_d;
   logic [AW-1:0] acc_q, acc_d, out_data_q, out_data_d;
   logic [3:0] tap_q, tap_d;
   logic [1:0] pos_q, pos_d, out_idx_q, out_idx_d;
   logic [1:0] ti, tj;
   logic [3:0] pidx;
   logic [DW-1:0] pix, flt;
   logic [2*DW-1:0] prod;
   logic [AW-1:0] sum;
   always_comb begin
      ti = 2'(tap_q / 4'd3);
      tj = 2'(tap_q % 4'd3);
      pidx = {ti + {1'b0, pos_q[1]}, 2'b00} + {2'b00, tj + {1'b0, pos_q[0]}};
      pix = in_q[DW*pidx +: DW];
      flt = filt_q[DW*tap_q +: DW];
      prod = pix * flt;
      sum = acc_q + AW'(prod);
   end
   always_comb begin
      state_d = state_q;
      in_d = in_q;
      filt_d = filt_q;
      acc_d = acc_q;
      tap_d = tap_q;
      pos_d = pos_q;
      out_data_d = out_data_q;
      out_idx_d = out_idx_q;
      case (state_q)
         IDLE: state_d = start ? LOAD : IDLE;
         LOAD: begin
            in_d = in_flat;
            filt_d = filt_flat;
            acc_d = '0;
            tap_d = '0;
            pos_d = '0;
            state_d = MAC;
         end
         MAC: begin
            acc_d = sum;
            tap_d = tap_q + 4'd1;
            if (tap_q == 4'd8) begin
               out_data_d = sum;
               out_idx_d = pos_q;
               state_d = EMIT;
            end
         end
         EMIT: if (out_ready) begin
            acc_d = '0;
            tap_d = '0;
            pos_d = pos_q + 2'd1;
            state_d = (pos_q == 2'd3) ? DONE : MAC;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         in_q <= '0;
         filt_q <= '0;
         acc_q <= '0;
         tap_q <= '0;
         pos_q <= '0;
         out_data_q <= '0;
         out_idx_q <= '0;
      end else begin
         state_q <= state_d;
         in_q <= in_d;
         filt_q <= filt_d;
         acc_q <= acc_d;
         tap_q <= tap_d;
         pos_q <= pos_d;
         out_data_q <= out_data_d;
         out_idx_q <= out_idx_d;
      end
   end
   assign busy = state_q != IDLE;
   assign out_valid = state_q == EMIT;
   assign done = state_q == DONE;
   assign out_data = out_data_q;
   assign out_idx = out_idx_q;
endmodule

// File: tb/tb_conv_reader.sv
// tb_conv_reader: directed checks of conv_reader timing, results, back-pressure, snapshot, reset and idle behaviour.
module tb_conv_reader;
   logic clk = 1'b0;
   logic rst, start, out_ready, busy, out_valid, done;
   logic [127:0] in_flat;
   logic [71:0] filt_flat;
   logic [19:0] out_data;
   logic [1:0] out_idx;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [19:0] exp_r [4];
   conv_reader #(.DW(8), .AW(20)) dut (
      .clk(clk), .rst(rst), .start(start), .in_flat(in_flat), .filt_flat(filt_flat),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .done(done)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s @%0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask
   task automatic set_std;
      logic [7:0] p [16] = '{112,224,174,135,41,225,115,246,49,73,215,106,59,227,21,64};
      logic [7:0] f [9] = '{70,87,210,89,191,144,184,113,177};
      for (int k = 0; k < 16; k++) in_flat[8*k +: 8] = p[k];
      for (int k = 0; k < 9; k++) filt_flat[8*k +: 8] = f[k];
      exp_r = '{20'd182372, 20'd193071, 20'd136083, 20'd195710};
   endtask
   task automatic run(input int stall, input bit zap);
      int dc, vc, idx;
      bit win, rdy;
      dc = 42 + 4*stall;
      start = 1'b1;
      out_ready = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= dc + 1; c++) begin
         win = 1'b0;
         rdy = 1'b1;
         idx = 0;
         for (int k = 0; k < 4; k++) begin
            vc = 11 + k*(10 + stall);
            if (c >= vc && c <= vc + stall) begin
               win = 1'b1;
               idx = k;
               if (c < vc + stall) rdy = 1'b0;
            end
         end
         out_ready = rdy;
         if (zap && c == 3) in_flat = '0;
         start = zap && c == 15;
         chk("out_valid", out_valid, win);
         chk("done", done, c == dc);
         chk("busy", busy, c <= dc);
         if (win) begin
            chk("out_data", out_data, exp_r[idx]);
            chk("out_idx", out_idx, idx);
         end
         tick;
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      in_flat = '0;
      filt_flat = '0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      set_std;
      run(0, 1'b0);
      set_std;
      run(5, 1'b0);
      for (int k = 0; k < 16; k++) in_flat[8*k +: 8] = 8'hff;
      for (int k = 0; k < 9; k++) filt_flat[8*k +: 8] = 8'hff;
      exp_r = '{20'd585225, 20'd585225, 20'd585225, 20'd585225};
      run(0, 1'b0);
      set_std;
      run(0, 1'b1);
      set_std;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c < 25; c++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      for (int c = 0; c < 30; c++) begin
         chk("mid_rst_done", done, 0);
         chk("mid_rst_idle", busy, 0);
         tick;
      end
      run(0, 1'b0);
      for (int c = 0; c < 100; c++) begin
         chk("idle_busy", busy, 0);
         chk("idle_valid", out_valid, 0);
         chk("idle_done", done, 0);
         tick;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
